sraml_arb_2x1: RTL and testbench



---
 rtl/sraml_arb_2x1.sv | 155 +++++++++++++++
 tb/tb_sraml_arb_2x1.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sraml_arb_2x1.sv
// rtl/sraml_arb_2x1.sv - two-master to one-slave sram-like arbiter with in-order completion routing
// Optional feature macro: SRAML_ARB_RR_EN (round-robin); default build is fixed priority, m1 over m0.
module sraml_arb_2x1 #(
  parameter int OUTST_DEPTH = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok
);

  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST_DEPTH);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t            lock_state;
  logic                   lock_id;
  logic                   sel;
  logic                   sel_req;
  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   pop;
  logic                   head_id;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OUTST_DEPTH-1:0] owner;
`ifdef SRAML_ARB_RR_EN
  logic                   last_gnt;
`endif

  // Grant selection: a pending lock pins the grant, otherwise arbitrate the live requests
  always_comb begin
    sel = 1'b1;
    if (lock_state == LOCKED) begin
      sel = lock_id;
    end else if (m0_req && m1_req) begin
`ifdef SRAML_ARB_RR_EN
      sel = ~last_gnt;
`else
      sel = 1'b1;
`endif
    end else if (m0_req) begin
      sel = 1'b0;
    end
  end

  assign sel_req = sel ? m1_req : m0_req;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

  // Requests are withheld while full and while reset is held, so nothing leaks out during reset
  assign s_req   = sel_req & ~full & ~rst;
  assign s_wr    = sel ? m1_wr    : m0_wr;
  assign s_size  = sel ? m1_size  : m0_size;
  assign s_addr  = sel ? m1_addr  : m0_addr;
  assign s_wdata = sel ? m1_wdata : m0_wdata;

  assign accept  = s_req & s_addr_ok;
  assign pop     = s_data_ok & ~empty & ~rst;
  assign head_id = owner[rd_ptr];

  assign m0_addr_ok = accept & ~sel;
  assign m1_addr_ok = accept & sel;
  assign m0_data_ok = pop & ~head_id;
  assign m1_data_ok = pop & head_id;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  // Lock FSM: hold the grant on a forwarded-but-unaccepted request until the slave takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= UNLOCKED;
      lock_id    <= 1'b0;
    end else begin
      case (lock_state)
        UNLOCKED: begin
          if (s_req && !s_addr_ok) begin
            lock_state <= LOCKED;
            lock_id    <= sel;
          end
        end
        LOCKED: begin
          if (s_addr_ok) lock_state <= UNLOCKED;
        end
        default: lock_state <= UNLOCKED;
      endcase
    end
  end

  // Owner FIFO: remembers which master issued each accepted transaction, in acceptance order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        owner[wr_ptr] <= sel;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SRAML_ARB_RR_EN
  // Round-robin history: remember who won the most recent accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_gnt <= 1'b0;
    else if (accept) last_gnt <= sel;
  end
`endif

`ifndef SYNTHESIS
  // Report completions that arrive with nothing outstanding
  always_ff @(posedge clk) begin
    if (!rst && s_data_ok && empty)
      $display("sraml_arb_2x1: s_data_ok with no outstanding transaction at %0t", $time);
  end
`endif

endmodule

// File: tb/tb_sraml_arb_2x1.sv
// tb/tb_sraml_arb_2x1.sv - randomized scoreboard bench for sraml_arb_2x1
module tb_sraml_arb_2x1;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [1:0]    m0_size = '0, m1_size = '0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic          s_req, s_wr;
  logic [1:0]    s_size;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata = '0;
  logic          s_addr_ok = 1'b0, s_data_ok = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference state: owner scoreboard, outstanding count, lock and last-grant bookkeeping
  int own_q[$];
  int mdl_cnt    = 0;
  int mdl_locked = 0;
  int mdl_who    = 0;
  int mdl_last   = 0;
  int slave_out  = 0;
  bit drop0 = 0, drop1 = 0;
  bit did_rst = 0;

  int p_req[4] = '{50, 95, 95, 80};
  int p_ack[4] = '{70, 40, 95, 50};
  int p_dok[4] = '{50, 50,  8, 90};

  sraml_arb_2x1 #(.OUTST_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
  endtask

  task automatic new_req(input int id);
    if (id == 0) begin
      m0_req = 1'b1; m0_wr = 1'($urandom); m0_size = 2'($urandom_range(0, 2));
      m0_addr = $urandom; m0_wdata = $urandom;
    end else begin
      m1_req = 1'b1; m1_wr = 1'($urandom); m1_size = 2'($urandom_range(0, 2));
      m1_addr = $urandom; m1_wdata = $urandom;
    end
  endtask

  // Expected grant from the arbitration rules, then compare the slave-side request and addr_ok
  task automatic eval_cycle();
    int sel;
    bit exp_sreq, acc;
    if (mdl_locked != 0) sel = mdl_who;
    else if (m0_req && m1_req) begin
`ifdef SRAML_ARB_RR_EN
      sel = (mdl_last == 1) ? 0 : 1;
`else
      sel = 1;
`endif
    end
    else if (m1_req) sel = 1;
    else if (m0_req) sel = 0;
    else sel = -1;
    exp_sreq = (sel >= 0) && (mdl_cnt < DEPTH);
    check("s_req", s_req, exp_sreq);
    if (exp_sreq) begin
      check("s_addr",  s_addr,  (sel == 1) ? m1_addr  : m0_addr);
      check("s_wr",    s_wr,    (sel == 1) ? m1_wr    : m0_wr);
      check("s_size",  s_size,  (sel == 1) ? m1_size  : m0_size);
      check("s_wdata", s_wdata, (sel == 1) ? m1_wdata : m0_wdata);
    end
    acc = exp_sreq && s_addr_ok;
    check("m0_addr_ok", m0_addr_ok, acc && sel == 0);
    check("m1_addr_ok", m1_addr_ok, acc && sel == 1);
    if (acc) begin
      own_q.push_back(sel);
      slave_out++;
      mdl_last = sel;
      if (sel == 0) drop0 = 1; else drop1 = 1;
    end
    if (exp_sreq && !s_addr_ok && mdl_locked == 0) begin
      mdl_locked = 1;
      mdl_who = sel;
    end else if (s_addr_ok) begin
      mdl_locked = 0;
    end
    mdl_cnt = mdl_cnt + (acc ? 1 : 0) - ((s_data_ok && mdl_cnt > 0) ? 1 : 0);
  endtask

  task automatic drive_cycle(input int ph);
    if (drop0) begin m0_req = 1'b0; drop0 = 0; end
    if (drop1) begin m1_req = 1'b0; drop1 = 0; end
    if (!m0_req && $urandom_range(0, 99) < p_req[ph]) new_req(0);
    if (!m1_req && $urandom_range(0, 99) < p_req[ph]) new_req(1);
    s_addr_ok = ($urandom_range(0, 99) < p_ack[ph]);
    s_data_ok = (slave_out > 0) && ($urandom_range(0, 99) < p_dok[ph]);
    if (s_data_ok) slave_out--;
    s_rdata = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_req"},      s_req,      1'b0);
    check({tag, "_m0_addr_ok"}, m0_addr_ok, 1'b0);
    check({tag, "_m1_addr_ok"}, m1_addr_ok, 1'b0);
    check({tag, "_m0_data_ok"}, m0_data_ok, 1'b0);
    check({tag, "_m1_data_ok"}, m1_data_ok, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle with traffic in flight
  task automatic do_reset();
    #1 rst = 1'b1;
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    #1 check_reset_outputs("mid_rst");
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    own_q.delete();
    mdl_cnt = 0; mdl_locked = 0; mdl_last = 0; slave_out = 0;
    drop0 = 0; drop1 = 0;
    did_rst = 1;
  endtask

  // Completion monitor: every data_ok must match the oldest expected owner
  always @(negedge clk) begin
    if (!rst) begin
      check("data_ok_any",  m0_data_ok | m1_data_ok, s_data_ok);
      check("data_ok_both", m0_data_ok & m1_data_ok, 1'b0);
      if (m0_data_ok || m1_data_ok) begin
        if (own_q.size() == 0) begin
          check("data_ok_unexpected", 1'b1, 1'b0);
        end else begin
          int e;
          e = own_q.pop_front();
          check("data_ok_owner", m1_data_ok, e == 1);
          check("m0_rdata", m0_rdata, s_rdata);
          check("m1_rdata", m1_rdata, s_rdata);
        end
      end
    end
  end

  initial begin
    new_req(0);
    new_req(1);
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    @(negedge clk);
    check_reset_outputs("init_rst");
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    #1 rst = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(posedge clk);
        #1 drive_cycle(ph);
        @(negedge clk);
        #2 eval_cycle();
        if (ph == 1 && !did_rst && cyc > 50 && mdl_cnt >= 2 && mdl_locked != 0) do_reset();
      end
      if (ph == 1 && !did_rst) do_reset();
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
